// File: rtl/io_pkg.sv
// io_pkg: register offsets and UART state encoding shared by the io_ctrl block
package io_pkg;
  localparam logic [15:0] IO_LED    = 16'h0000;
  localparam logic [15:0] IO_SW     = 16'h0004;
  localparam logic [15:0] IO_COUNT  = 16'h0008;
  localparam logic [15:0] IO_CMP    = 16'h000C;
  localparam logic [15:0] IO_STAT   = 16'h0010;
  localparam logic [15:0] IO_TXDATA = 16'h0014;
  localparam logic [15:0] IO_TXSTAT = 16'h0018;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
endpackage

// File: rtl/io_uart_tx.sv
// io_uart_tx: 8N1 serial transmitter, CLK_DIV clocks per bit
module io_uart_tx import io_pkg::*; #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);
  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  uart_state_t state, state_nx;
  logic [W-1:0] cnt, cnt_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] sh, sh_nx;
  logic tick;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      sh <= sh_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = tick ? '0 : cnt + W'(1);
    idx_nx = idx;
    sh_nx = sh;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start) begin
          state_nx = START;
          sh_nx = data;
          idx_nx = '0;
        end
      end
      START: state_nx = tick ? DATA : START;
      DATA: if (tick) begin
        idx_nx = idx + 3'd1;
        state_nx = idx == 3'd7 ? STOP : DATA;
      end
      STOP: state_nx = tick ? IDLE : STOP;
    endcase
  end
  assign busy = state != IDLE;
  // line level derives from state so an async reset forces idle-high at once
  assign tx = state == START ? 1'b0 : state == DATA ? sh[idx] : 1'b1;
endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped LED, switch, timer and UART peripherals for the IO window
module io_ctrl import io_pkg::*; #(
  parameter int CLK_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_ce,
  input  logic        io_we,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_din,
  output logic [31:0] io_dout,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        uart_tx,
  output logic        timer_irq
);
  logic [15:0] off, sw_m, sw_s;
  logic [31:0] count, cmp;
  logic wr, pending, busy, unused;
  assign off = io_addr[15:0];
  assign wr = io_ce & io_we;
  assign unused = ^io_addr[31:16];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      led <= '0;
      sw_m <= '0;
      sw_s <= '0;
      count <= '0;
      cmp <= '0;
      pending <= 1'b0;
    end else begin
      sw_m <= sw;
      sw_s <= sw_m;
      if (wr && off == IO_LED) led <= io_din[15:0];
      count <= (wr && off == IO_COUNT) ? io_din : count + 32'd1;
      if (wr && off == IO_CMP) cmp <= io_din;
      // a match in the same cycle as a clear keeps the interrupt pending
      if (cmp != '0 && count == cmp) pending <= 1'b1;
      else if (wr && off == IO_STAT && io_din[0]) pending <= 1'b0;
    end
  assign timer_irq = pending;
  io_uart_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk(clk),
    .rst(rst),
    .start(wr && off == IO_TXDATA),
    .data(io_din[7:0]),
    .busy(busy),
    .tx(uart_tx)
  );
  always_comb begin
    io_dout = '0;
    if (io_ce)
      case (off)
        IO_LED:    io_dout = {16'd0, led};
        IO_SW:     io_dout = {16'd0, sw_s};
        IO_COUNT:  io_dout = count;
        IO_CMP:    io_dout = cmp;
        IO_STAT:   io_dout = {31'd0, pending};
        IO_TXSTAT: io_dout = {31'd0, busy};
        default:   io_dout = '0;
      endcase
  end
endmodule

// File: tb/tb_io_ctrl.sv
// tb_io_ctrl: vector table, directed corner cases and random traffic against a cycle model
module tb_io_ctrl;
  localparam int CLK_DIV = 4;
  localparam logic [31:0] B = 32'hBFD0_0000;
  logic clk = 0, rst = 1, io_ce = 0, io_we = 0;
  logic [31:0] io_addr = 0, io_din = 0, io_dout;
  logic [15:0] sw = 0, led;
  logic uart_tx, timer_irq;
  int n_cmp = 0, n_bad = 0;

  io_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .io_ce(io_ce), .io_we(io_we), .io_addr(io_addr),
    .io_din(io_din), .io_dout(io_dout), .sw(sw), .led(led),
    .uart_tx(uart_tx), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  logic [15:0] m_led, m_sw1, m_sw2;
  logic [31:0] m_count, m_cmp;
  logic m_pend, m_act;
  int m_pos;
  logic [9:0] m_frame;

  task automatic mreset();
    m_led = 0; m_sw1 = 0; m_sw2 = 0; m_count = 0; m_cmp = 0;
    m_pend = 0; m_act = 0; m_pos = 0; m_frame = '1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [15:0] o);
    case (o)
      16'h0000: return {16'd0, m_led};
      16'h0004: return {16'd0, m_sw2};
      16'h0008: return m_count;
      16'h000C: return m_cmp;
      16'h0010: return {31'd0, m_pend};
      16'h0018: return {31'd0, m_act};
      default:  return 32'd0;
    endcase
  endfunction

  // one clock edge; model advances from the inputs held before the edge
  task automatic step();
    logic w, acc, match, clr;
    logic [15:0] o, swv;
    logic [31:0] d;
    w = io_ce && io_we; o = io_addr[15:0]; d = io_din; swv = sw;
    match = m_cmp != 0 && m_count == m_cmp;
    clr = w && o == 16'h0010 && d[0];
    acc = w && o == 16'h0014 && !m_act;
    @(posedge clk); #1;
    m_sw2 = m_sw1; m_sw1 = swv;
    m_pend = match || (m_pend && !clr);
    m_count = (w && o == 16'h0008) ? d : m_count + 1;
    if (w && o == 16'h0000) m_led = d[15:0];
    if (w && o == 16'h000C) m_cmp = d;
    if (acc) begin
      m_frame = {1'b1, d[7:0], 1'b0}; m_act = 1; m_pos = 0;
    end else if (m_act) begin
      m_pos++;
      if (m_pos == 10 * CLK_DIV) m_act = 0;
    end
    chk("led", {16'd0, led}, {16'd0, m_led});
    chk("irq", {31'd0, timer_irq}, {31'd0, m_pend});
    chk("tx", {31'd0, uart_tx}, {31'd0, m_act ? m_frame[m_pos / CLK_DIV] : 1'b1});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_ce = 1; io_we = 1; io_addr = a; io_din = d;
    step();
    io_ce = 0; io_we = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    io_ce = 1; io_we = 0; io_addr = a;
    #1 v = io_dout;
    io_ce = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && m_act; i++) step();
    chk("wait_idle", {31'd0, m_act}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [15:0] ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[9];
  logic [15:0] offs[8] = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h14, 16'h18, 16'h20};

  initial begin
    logic [31:0] v;
    logic [9:0] exp_bits;
    int busy_n;
    vt[0] = '{B | 32'h00, 32'hDEAD_BEEF, 16'h0000, 32'h0000_BEEF};
    vt[1] = '{B | 32'h20, 32'h1234_5678, 16'h0020, 32'h0};
    vt[2] = '{B | 32'h20, 32'h0,         16'h0000, 32'h0000_BEEF};
    vt[3] = '{32'h1234_0000, 32'hFFFF_0001, 16'h0000, 32'h0000_0001};
    vt[4] = '{B | 32'h0C, 32'hCAFE_0000, 16'h000C, 32'hCAFE_0000};
    vt[5] = '{B | 32'h10, 32'h0,         16'h0010, 32'h0};
    vt[6] = '{B | 32'h14, 32'h0000_00FF, 16'h0014, 32'h0};
    vt[7] = '{B | 32'h1C, 32'hFFFF_FFFF, 16'h0018, 32'h1};
    vt[8] = '{B | 32'h18, 32'h0,         16'h000C, 32'hCAFE_0000};
    mreset();
    sw = 16'h5A5A;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_led", {16'd0, led}, 32'd0);
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    foreach (offs[i]) begin
      rd(B | offs[i], v);
      chk("rst_rd", v, 32'd0);
    end
    @(posedge clk); #1;
    rst = 0; sw = 0;
    mreset();
    for (int i = 0; i < 9; i++) begin
      wr(vt[i].wa, vt[i].wd);
      rd(B | vt[i].ra, v);
      chk($sformatf("vec%0d", i), v, vt[i].exp);
    end
    wait_idle();
    sw = 16'h1234;
    step();
    rd(B | 32'h4, v);
    chk("sw_early", v, 32'h0);
    step(); step();
    rd(B | 32'h4, v);
    chk("sw_sync", v, 32'h1234);
    wr(B | 32'h10, 1);
    wr(B | 32'h08, 32'hFFFF_FFFE);
    rd(B | 32'h08, v);
    chk("cnt_load", v, 32'hFFFF_FFFE);
    wr(B | 32'h0C, 32'h1);
    rd(B | 32'h08, v);
    chk("cnt_pre", v, 32'hFFFF_FFFF);
    step();
    rd(B | 32'h08, v);
    chk("cnt_wrap", v, 32'h0);
    step();
    rd(B | 32'h08, v);
    chk("cnt_one", v, 32'h1);
    chk("irq_not_yet", {31'd0, timer_irq}, 32'd0);
    step();
    chk("irq_rise", {31'd0, timer_irq}, 32'd1);
    wr(B | 32'h10, 0);
    chk("irq_hold", {31'd0, timer_irq}, 32'd1);
    wr(B | 32'h10, 1);
    chk("irq_clr", {31'd0, timer_irq}, 32'd0);
    wr(B | 32'h0C, 32'd20);
    wr(B | 32'h08, 32'd17);
    step(); step(); step();
    rd(B | 32'h08, v);
    chk("cnt_at_cmp", v, 32'd20);
    wr(B | 32'h10, 1);
    chk("irq_set_wins", {31'd0, timer_irq}, 32'd1);
    wr(B | 32'h10, 1);
    wr(B | 32'h0C, 0);
    wr(B | 32'h08, 32'hFFFF_FFFF);
    step(); step(); step();
    chk("cmp0_off", {31'd0, timer_irq}, 32'd0);
    exp_bits = 10'b11_0100_1010;
    wr(B | 32'h14, 32'hA5);
    busy_n = 0;
    for (int i = 0; i < 60; i++) begin
      rd(B | 32'h18, v);
      if (v[0] == 1'b0) break;
      chk("a5_bit", {31'd0, uart_tx}, {31'd0, exp_bits[busy_n / CLK_DIV]});
      busy_n++;
      if (busy_n == 10) wr(B | 32'h14, 32'h00);
      else step();
    end
    chk("busy_len", busy_n, 10 * CLK_DIV);
    for (int i = 0; i < 8; i++) step();
    rd(B | 32'h18, v);
    chk("no_second_frame", v, 32'd0);
    for (int i = 0; i < 2000; i++) begin
      int op;
      logic [15:0] o;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      o = offs[$urandom_range(0, 7)];
      if (op < 3) begin
        d = $urandom;
        if (o == 16'h8 && $urandom_range(0, 1) == 1) d = m_cmp - 32'($urandom_range(0, 5));
        if (o == 16'hC && $urandom_range(0, 1) == 1) d = m_count + 32'($urandom_range(1, 8));
        wr({16'hBFD0, o}, d);
      end else if (op < 8) begin
        rd({16'($urandom), o}, v);
        chk("rand_rd", v, mrd(o));
        step();
      end else if (op == 8) begin
        io_ce = 0; io_we = 0; io_addr = {16'hBFD0, o};
        #1 chk("ce_low", io_dout, 32'd0);
        step();
      end else step();
    end
    wait_idle();
    wr(B | 32'h0, 32'hFFFF);
    wr(B | 32'h0C, 0);
    wr(B | 32'h10, 1);
    wr(B | 32'h08, 32'd100);
    wr(B | 32'h0C, 32'd102);
    step(); step();
    chk("pre_rst_irq", {31'd0, timer_irq}, 32'd1);
    wr(B | 32'h14, 32'h00);
    step(); step();
    chk("pre_rst_tx", {31'd0, uart_tx}, 32'd0);
    #2 rst = 1;
    #1;
    chk("async_tx", {31'd0, uart_tx}, 32'd1);
    chk("async_led", {16'd0, led}, 32'd0);
    chk("async_irq", {31'd0, timer_irq}, 32'd0);
    foreach (offs[i]) begin
      rd(B | offs[i], v);
      chk("mid_rst_rd", v, 32'd0);
    end
    @(posedge clk); #1;
    rst = 0;
    mreset();
    for (int i = 0; i < 50; i++) step();
    rd(B | 32'h18, v);
    chk("post_rst_idle", v, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
